// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with wrap-bit pointers, threshold flags,
// sticky error flags and a choice of registered-read or first-word-fall-through output.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk_single_domain,
  input  logic                     rst,
  input  logic                     wen,
  input  logic [DATA_W-1:0]        from_user,
  input  logic                     ren,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        to_the_user,
  output logic                     rvalid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_L = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_L = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     wr_ptr;
  logic [CW-1:0]     rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  // Flags come only from registered pointers, so no input reaches an output combinationally.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (count >= AF_L);
  assign almost_empty = (count <= AE_L);

  assign wr_acc = wen && !full;
  assign rd_acc = ren && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_single_domain or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + CW'(1);
      // A fresh error wins over a coincident clear.
      overflow  <= (overflow  && !clr_err) || (wen && full);
      underflow <= (underflow && !clr_err) || (ren && empty);
    end
  end

  // NOTE: storage has no reset; stale words are unreachable once the pointers are cleared.
  always_ff @(posedge clk_single_domain) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= from_user;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented straight from storage; it is registered state, not an input path.
      // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
      always_comb begin
        to_the_user = empty ? '0 : mem[rd_ptr[AW-1:0]];
        rvalid      = !empty;
      end
    end else begin : g_reg_read
      always_ff @(posedge clk_single_domain or posedge rst) begin
        if (rst) begin
          to_the_user <= '0;
          rvalid      <= 1'b0;
        end else begin
          rvalid <= rd_acc;
          if (rd_acc) to_the_user <= mem[rd_ptr[AW-1:0]];
        end
      end
    end
  endgenerate

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high, with ports named clk_single_domain and rst.
REQ-002 Parameter DATA_W, default 8: word width in bits.
REQ-003 Parameter DEPTH, default 16: entry count; power of two, at least 4.
REQ-004 Parameter AF_LEVEL, default DEPTH-2: almost_full threshold.
REQ-005 Parameter AE_LEVEL, default 2: almost_empty threshold.
REQ-006 Parameter FWFT, default 0: 0 selects registered-read mode, 1 selects first-word-fall-through mode.
REQ-007 Ports SHALL be as follows (CW = log2(DEPTH)+1):
- clk_single_domain  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous active-high reset
- wen  in  1  write request
- from_user  in  DATA_W  write data
- ren  in  1  read request
- clr_err  in  1  synchronous clear of the sticky error flags
- to_the_user  out  DATA_W  read data
- rvalid  out  1  to_the_user holds valid data
- full, empty  out  1  occupancy flags
- almost_full, almost_empty  out  1  threshold flags
- count  out  CW  current occupancy, 0..DEPTH
- overflow, underflow  out  1  sticky error flags

Function
REQ-008 A write SHALL be accepted when wen=1 and full=0: from_user is stored at the write pointer, and the write pointer increments.
REQ-009 A read SHALL be accepted when ren=1 and empty=0: the read pointer increments.
REQ-010 Pointers SHALL be log2(DEPTH)+1 bits wide; the extra MSB is a wrap bit, and address bits wrap from DEPTH-1 to 0.
REQ-011 The flags SHALL be decoded from registered pointers only:
- empty: pointers equal
- full: address bits equal and wrap bits differ
- count: write pointer minus read pointer, modulo 2*DEPTH
REQ-012 almost_full SHALL be 1 when count >= AF_LEVEL; almost_empty SHALL be 1 when count <= AE_LEVEL.
REQ-013 Accepted write plus accepted read in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-014 When the FIFO is full, wen=1 with ren=1 SHALL accept only the read; the write is dropped and overflow is set.
REQ-015 When the FIFO is empty, wen=1 with ren=1 SHALL accept only the write; the read is rejected and underflow is set.
REQ-016 wen=1 while full SHALL set overflow and drop the data; ren=1 while empty SHALL set underflow and move no pointer.
REQ-017 overflow and underflow SHALL stay set until clr_err=1; if a new error coincides with clr_err, the flag SHALL stay set.
REQ-018 With FWFT=0, an accepted read SHALL register the head word into to_the_user, with rvalid=1 for exactly the following cycle (latency 1).
REQ-019 With FWFT=0, rvalid SHALL be 0 in any cycle not following an accepted read, and to_the_user SHALL hold its last value.
REQ-020 With FWFT=1, to_the_user SHALL present the head word whenever empty=0, and rvalid SHALL equal not-empty.
REQ-021 With FWFT=1, ren SHALL pop the head, and the next word SHALL appear in the cycle after the pop.
REQ-022 With FWFT=1, a word written into an empty FIFO SHALL appear with rvalid=1 one cycle after the write edge.
REQ-023 No combinational path SHALL exist from wen, ren or from_user to any output.

Reset
REQ-024 While rst=1, the following SHALL hold immediately, independent of the clock:
- pointers=0, count=0
- empty=1, almost_empty=1, full=0, almost_full=0
- rvalid=0, to_the_user=0
- overflow=0, underflow=0
REQ-025 Storage contents SHALL NOT be reset; reset mid-operation discards all stored words.
REQ-026 After rst falls, the first accepted write SHALL be possible on the next rising edge.

Verification
REQ-027 The bench SHALL cover the following scenarios with DATA_W=8, DEPTH=16 unless stated:
- Fill, overflow: 16 writes 0x01..0x10, no reads -> almost_full at count=14, full=1 and count=16 after the 16th edge; 17th write 0xFF -> overflow=1, count=16.
- Drain, underflow (FWFT=0): 16 reads -> to_the_user 0x01..0x10, each one cycle after its ren with rvalid=1; empty=1 after the last; extra ren -> underflow=1, rvalid=0.
- Simultaneous: at count=5, wen=ren=1 for 3 cycles -> count stays 5, output order unchanged; clr_err=1 clears overflow/underflow next edge.
- Wrap: 40 interleaved write/read pairs with random data -> both pointers wrap at least twice, every output matches the write order.
- FWFT=1: write 0xA5 to empty -> next cycle rvalid=1 and to_the_user=0xA5 with no ren; ren=1 -> rvalid=0 the following cycle.
- Async reset: rst pulsed mid-cycle at count=9 -> all REQ-024 values immediately, before the next clock edge.
